// File: rtl/mmio_timer_console_if.sv
// Bus and console signals of the MMIO timer/console peripheral.
// The master side is the core data port together with the console byte sink.
interface mmio_timer_console_if;
   logic [31:0] data_address;
   logic [1:0]  data_width;
   logic [31:0] data_in;
   logic        data_read;
   logic        data_write;
   logic [31:0] data_out;
   logic        sel;
   logic        irq;
   logic        bus_error;
   logic        tx_valid;
   logic [7:0]  tx_data;
   logic        tx_ready;

   modport master (
      output data_address, data_width, data_in, data_read, data_write, tx_ready,
      input  data_out, sel, irq, bus_error, tx_valid, tx_data
   );

   modport slave (
      input  data_address, data_width, data_in, data_read, data_write, tx_ready,
      output data_out, sel, irq, bus_error, tx_valid, tx_data
   );
endinterface

// File: rtl/mmio_timer_console.sv
// Memory-mapped timer (prescaler, compare, auto-reload, irq), buffered debug console
// and sticky bus-error detection, sitting beside data RAM on the core data port.
module mmio_timer_console #(
   parameter logic [31:0] BASE_ADDR   = 32'h4000_0000,
   parameter int unsigned MEM_BYTES   = 2**16,
   parameter logic [31:0] NULL_GUARD  = 32'h100,
   parameter int          TIMER_WIDTH = 32,
   parameter int unsigned DIV_RESET   = 100,
   parameter int          FIFO_DEPTH  = 16
) (
   input logic                 clock,
   input logic                 reset,
   mmio_timer_console_if.slave bus
);
   localparam int TW = TIMER_WIDTH;
   localparam int AW = $clog2(FIFO_DEPTH);
   localparam int CW = AW + 1;
   localparam logic [TW-1:0] DIV_INIT = TW'(DIV_RESET);
   localparam logic [CW-1:0] DEPTH    = CW'(FIFO_DEPTH);

   typedef enum logic [2:0] {
      REG_CTRL    = 3'd0,
      REG_CONSOLE = 3'd1,
      REG_TIMER   = 3'd2,
      REG_DIVIDER = 3'd3,
      REG_COMPARE = 3'd4,
      REG_STATUS  = 3'd5
   } reg_e;

   // ---------------------------------------------------------------- decode
   logic sel;
   reg_e offset;
   logic word_access;
   logic is_reg;
   logic reg_wr;
   logic subword_err;
   logic access_err;
   logic wr_ctrl, wr_timer, wr_divider, wr_compare, wr_status;
   logic push_req;

   // The window is 32-byte aligned, so the upper address bits identify it.
   assign sel         = (bus.data_address[31:5] == BASE_ADDR[31:5]);
   assign offset      = reg_e'(bus.data_address[4:2]);
   assign word_access = (bus.data_width == 2'd2);
   assign is_reg      = offset inside {REG_CTRL, REG_TIMER, REG_DIVIDER, REG_COMPARE, REG_STATUS};
   assign reg_wr      = bus.data_write && sel && word_access;

   assign wr_ctrl    = reg_wr && (offset == REG_CTRL);
   assign wr_timer   = reg_wr && (offset == REG_TIMER);
   assign wr_divider = reg_wr && (offset == REG_DIVIDER);
   assign wr_compare = reg_wr && (offset == REG_COMPARE);
   assign wr_status  = reg_wr && (offset == REG_STATUS);
   assign push_req   = bus.data_write && sel && (offset == REG_CONSOLE);

   assign subword_err = bus.data_write && sel && !word_access && is_reg;
   assign access_err  = (bus.data_read || bus.data_write) &&
                        ((bus.data_address < NULL_GUARD) ||
                         ((bus.data_address >= MEM_BYTES) && !sel) ||
                         subword_err);

   // ----------------------------------------------------------------- state
   logic [2:0]    ctrl_q;
   logic [TW-1:0] timer_q, divider_q, compare_q, prescaler_q;
   logic [2:0]    status_q;
   logic          irq_q;
   logic          bus_error_q;

   logic timer_en, irq_en, auto_reload;
   assign timer_en    = ctrl_q[0];
   assign irq_en      = ctrl_q[1];
   assign auto_reload = ctrl_q[2];

   // ----------------------------------------------------------------- fifo
   logic [7:0]    fifo_mem [FIFO_DEPTH];
   logic [AW-1:0] wr_ptr_q, rd_ptr_q;
   logic [CW-1:0] count_q;
   logic          full, empty, pop, push_ok, overflow;

   assign full     = (count_q == DEPTH);
   assign empty    = (count_q == '0);
   assign pop      = !empty && bus.tx_ready;
   // A push into a full FIFO still lands when the head leaves in the same cycle.
   assign push_ok  = push_req && (!full || pop);
   assign overflow = push_req && full && !pop;

   // ---------------------------------------------------------------- timer
   logic [TW-1:0] timer_inc, timer_d, prescaler_d;
   logic          tick, match;

   always_comb begin
      // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
      timer_inc   = timer_q + TW'(1);
      tick        = timer_en && (prescaler_q == divider_q);
      match       = tick && !wr_timer && (timer_inc == compare_q);
      timer_d     = timer_q;
      prescaler_d = prescaler_q;

      if (timer_en) begin
         prescaler_d = tick ? '0 : prescaler_q + TW'(1);
      end
      if (tick) begin
         timer_d = (match && auto_reload) ? '0 : timer_inc;
      end
      // Software writes override the increment and restart the prescale period.
      if (wr_timer) begin
         timer_d     = bus.data_in[TW-1:0];
         prescaler_d = '0;
      end
      if (wr_divider) begin
         prescaler_d = '0;
      end
   end

   logic [2:0] status_set, status_clr;
   assign status_set = {access_err, overflow, match};
   assign status_clr = wr_status ? bus.data_in[2:0] : 3'b000;

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         ctrl_q      <= '0;
         timer_q     <= '0;
         divider_q   <= DIV_INIT;
         compare_q   <= '1;
         prescaler_q <= '0;
         status_q    <= '0;
         irq_q       <= 1'b0;
         bus_error_q <= 1'b0;
         wr_ptr_q    <= '0;
         rd_ptr_q    <= '0;
         count_q     <= '0;
      end else begin
         // NOTE: non-blocking, so irq_q samples the status/enable held before this edge.
         if (wr_ctrl)    ctrl_q    <= bus.data_in[2:0];
         if (wr_divider) divider_q <= bus.data_in[TW-1:0];
         if (wr_compare) compare_q <= bus.data_in[TW-1:0];
         timer_q     <= timer_d;
         prescaler_q <= prescaler_d;
         // Set events are OR-ed after the clear so a same-cycle set wins.
         status_q    <= (status_q & ~status_clr) | status_set;
         irq_q       <= status_q[0] & irq_en;
         bus_error_q <= access_err;

         if (push_ok) wr_ptr_q <= wr_ptr_q + AW'(1);
         if (pop)     rd_ptr_q <= rd_ptr_q + AW'(1);
         case ({push_ok, pop})
            2'b10:   count_q <= count_q + CW'(1);
            2'b01:   count_q <= count_q - CW'(1);
            default: count_q <= count_q;
         endcase
      end
   end

   // NOTE: storage array has no reset; the pointers and count alone define its contents.
   always_ff @(posedge clock) begin
      if (push_ok) begin
         fifo_mem[wr_ptr_q] <= bus.data_in[7:0];
      end
   end

   // -------------------------------------------------------------- read mux
   logic [31:0] rdata;

   always_comb begin
      rdata = '0;
      if (sel) begin
         case (offset)
            REG_CTRL:    rdata = {29'b0, ctrl_q};
            REG_CONSOLE: rdata = {16'(count_q), 14'b0, full, empty};
            REG_TIMER:   rdata = 32'(timer_q);
            REG_DIVIDER: rdata = 32'(divider_q);
            REG_COMPARE: rdata = 32'(compare_q);
            REG_STATUS:  rdata = {29'b0, status_q};
            default:     rdata = '0;
         endcase
      end
   end

   assign bus.data_out  = rdata;
   assign bus.sel       = sel;
   assign bus.irq       = irq_q;
   assign bus.bus_error = bus_error_q;
   assign bus.tx_valid  = !empty;
   // Gated so the byte sink sees zero while nothing is queued, including in reset.
   assign bus.tx_data   = empty ? 8'h00 : fifo_mem[rd_ptr_q];

endmodule
